// File: rtl/sched_window.sv
`default_nettype none
// ============================================================================
//  Module      : sched_window
//  Description : Collapsing out-of-order issue window. Entries are held in age
//                order (slot 0 oldest). Each cycle the oldest entry that has
//                no hazard against any older entry issues into a front
//                register. Younger entries shift down to close the gap.
//                Load data returning by tag wakes waiting entries.
//  Revision    : 1.0  initial release
// ============================================================================
module sched_window #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 3,
    parameter int PAYLOAD_W = 21
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   id_feed,
    output logic                   id_req,
    input  logic [PAYLOAD_W-1:0]   id_payload,
    input  logic [15:0]            id_k16,
    input  logic [2:0]             id_a_adr,
    input  logic [2:0]             id_b_adr,
    input  logic [3:0]             id_d_adr,
    input  logic                   id_sf,
    input  logic                   id_ld,
    input  logic                   id_st,
    input  logic                   id_wait,
    input  logic                   lsu_data_wb,
    input  logic [TAG_W-1:0]       lsu_data_tag,
    input  logic [15:0]            lsu_data_in,
    input  logic                   lsu_wait,
    output logic                   iss_valid,
    output logic [PAYLOAD_W-1:0]   iss_payload,
    output logic [15:0]            iss_k16,
    output logic [3:0]             iss_d_adr,
    output logic                   iss_sf,
    output logic [TAG_W-1:0]       iss_tag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [15:0]          k16;
        logic [2:0]           a;
        logic [2:0]           b;
        logic [3:0]           d;
        logic                 sf;
        logic                 ld;
        logic                 st;
        logic                 wt;
        logic [TAG_W-1:0]     tag;
    } entry_t;

    entry_t               r_win [DEPTH];
    entry_t               w_win_nxt [DEPTH];
    entry_t               w_new;
    logic [CNT_W-1:0]     r_count;
    logic [TAG_W-1:0]     r_tag;
    logic [DEPTH-1:0]     w_elig;
    logic                 w_issue;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_alloc;
    logic [CNT_W-1:0]     w_slot;

    logic                 r_iss_valid;
    logic [PAYLOAD_W-1:0] r_iss_payload;
    logic [15:0]          r_iss_k16;
    logic [3:0]           r_iss_d_adr;
    logic                 r_iss_sf;
    logic [TAG_W-1:0]     r_iss_tag;

    // True when younger entry y may not pass older entry o.
    function automatic logic f_hazard(input entry_t y, input entry_t o);
        logic raw, war, waw, flg, mem;
        raw = o.d[3] & ((o.d[2:0] == y.a) | (o.d[2:0] == y.b));
        war = y.d[3] & ((y.d[2:0] == o.a) | (y.d[2:0] == o.b));
        waw = y.d[3] & o.d[3] & (y.d[2:0] == o.d[2:0]);
        flg = y.sf & o.sf;
        mem = (y.ld | y.st) & (o.st | (y.st & o.ld));
        return raw | war | waw | flg | mem;
    endfunction

    assign id_req  = (r_count < c_DEPTH_CNT);
    assign w_alloc = id_feed & id_req;
    assign count   = r_count;

    // An entry is eligible when ready and clear of every older valid entry.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_elig[i] = r_win[i].valid & ~r_win[i].wt;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j < i) && r_win[j].valid && f_hazard(r_win[i], r_win[j]))
                    w_elig[i] = 1'b0;
            end
        end
    end

    // Oldest eligible entry wins; nothing leaves the window while the LSU stalls.
    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_issue = ~lsu_wait;
                w_sel   = IDX_W'(i);
            end
        end
    end

    // Incoming uop, as it will be stored.
    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.payload = id_payload;
        w_new.k16     = id_k16;
        w_new.a       = id_a_adr;
        w_new.b       = id_b_adr;
        w_new.d       = id_d_adr;
        w_new.sf      = id_sf;
        w_new.ld      = id_ld;
        w_new.st      = id_st;
        w_new.wt      = id_wait;
        w_new.tag     = r_tag;
    end

    // Next window: collapse over the issued slot, apply wake-up, then append.
    always_comb begin
        w_slot = w_issue ? (r_count - CNT_W'(1)) : r_count;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_issue && (k >= int'(w_sel))) begin
                if (k == DEPTH - 1)
                    w_win_nxt[k] = '0;
                else
                    w_win_nxt[k] = r_win[(k + 1) % DEPTH];
            end else begin
                w_win_nxt[k] = r_win[k];
            end
            if (lsu_data_wb && w_win_nxt[k].valid && w_win_nxt[k].wt &&
                (w_win_nxt[k].tag == lsu_data_tag)) begin
                w_win_nxt[k].k16 = lsu_data_in;
                w_win_nxt[k].wt  = 1'b0;
            end
            if (w_alloc && (int'(w_slot) == k))
                w_win_nxt[k] = w_new;
        end
    end

    // Window storage, occupancy and allocation tag.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_win[k] <= '0;
            r_count <= '0;
            r_tag   <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                r_win[k] <= w_win_nxt[k];
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);
            if (w_alloc)
                r_tag <= r_tag + TAG_W'(1);
        end
    end

    // Front register: load the selected uop or a bubble, hold during LSU stall.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_iss_valid   <= 1'b0;
            r_iss_payload <= '0;
            r_iss_k16     <= '0;
            r_iss_d_adr   <= '0;
            r_iss_sf      <= 1'b0;
            r_iss_tag     <= '0;
        end else if (!lsu_wait) begin
            r_iss_valid <= w_issue;
            if (w_issue) begin
                r_iss_payload <= r_win[w_sel].payload;
                r_iss_k16     <= r_win[w_sel].k16;
                r_iss_d_adr   <= r_win[w_sel].d;
                r_iss_sf      <= r_win[w_sel].sf;
                r_iss_tag     <= r_win[w_sel].tag;
            end else begin
                r_iss_payload <= '0;
                r_iss_k16     <= '0;
                r_iss_d_adr   <= '0;
                r_iss_sf      <= 1'b0;
                r_iss_tag     <= '0;
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_payload = r_iss_payload;
    assign iss_k16     = r_iss_k16;
    assign iss_d_adr   = r_iss_d_adr;
    assign iss_tag     = r_iss_tag;
    // Flag write is only committed while the LSU is not stalling the front.
    assign iss_sf      = r_iss_valid & r_iss_sf & ~lsu_wait;

endmodule
`default_nettype wire

// File: tb/tb_sched_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sched_window
//  Description : Directed bench for sched_window with an age-ordered queue
//                model and literal checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sched_window;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;
    localparam int PW    = 21;

    logic             clk = 1'b0;
    logic             a_rst;
    logic             id_feed;
    logic             id_req;
    logic [PW-1:0]    id_payload;
    logic [15:0]      id_k16;
    logic [2:0]       id_a_adr;
    logic [2:0]       id_b_adr;
    logic [3:0]       id_d_adr;
    logic             id_sf, id_ld, id_st, id_wait;
    logic             lsu_data_wb;
    logic [TAG_W-1:0] lsu_data_tag;
    logic [15:0]      lsu_data_in;
    logic             lsu_wait;
    logic             iss_valid;
    logic [PW-1:0]    iss_payload;
    logic [15:0]      iss_k16;
    logic [3:0]       iss_d_adr;
    logic             iss_sf;
    logic [TAG_W-1:0] iss_tag;
    logic [2:0]       count;

    always #5 clk = ~clk;

    sched_window #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
        .clk(clk), .a_rst(a_rst), .id_feed(id_feed), .id_req(id_req),
        .id_payload(id_payload), .id_k16(id_k16), .id_a_adr(id_a_adr),
        .id_b_adr(id_b_adr), .id_d_adr(id_d_adr), .id_sf(id_sf), .id_ld(id_ld),
        .id_st(id_st), .id_wait(id_wait), .lsu_data_wb(lsu_data_wb),
        .lsu_data_tag(lsu_data_tag), .lsu_data_in(lsu_data_in),
        .lsu_wait(lsu_wait), .iss_valid(iss_valid), .iss_payload(iss_payload),
        .iss_k16(iss_k16), .iss_d_adr(iss_d_adr), .iss_sf(iss_sf),
        .iss_tag(iss_tag), .count(count)
    );

    typedef struct {
        logic [PW-1:0]    payload;
        logic [15:0]      k16;
        logic [2:0]       a, b;
        logic [3:0]       d;
        logic             sf, ld, st, wt;
        logic [TAG_W-1:0] tag;
    } uop_t;

    // Model: age-ordered list of uops plus the front register contents.
    uop_t             m_q[$];
    logic [TAG_W-1:0] m_tag  = '0;
    logic             m_fv   = 1'b0;
    logic [PW-1:0]    m_fpay = '0;
    logic [15:0]      m_fk16 = '0;
    logic [3:0]       m_fd   = '0;
    logic             m_fsf  = 1'b0;
    logic [TAG_W-1:0] m_ftag = '0;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Ordering rules between a younger uop y and an older uop o.
    function automatic bit m_conflict(input uop_t y, input uop_t o);
        bit raw, war, waw, flg, mem;
        raw = o.d[3] && (o.d[2:0] == y.a || o.d[2:0] == y.b);
        war = y.d[3] && (y.d[2:0] == o.a || y.d[2:0] == o.b);
        waw = y.d[3] && o.d[3] && (y.d[2:0] == o.d[2:0]);
        flg = y.sf && o.sf;
        mem = (y.ld || y.st) && (o.st || (y.st && o.ld));
        return raw || war || waw || flg || mem;
    endfunction

    // Advance the model on every active edge from the inputs it sees there.
    always @(posedge clk) begin
        int   sel;
        bit   req;
        bit   ok;
        uop_t u;
        if (a_rst) begin
            m_q.delete();
            m_tag = '0; m_fv = 1'b0; m_fpay = '0; m_fk16 = '0;
            m_fd = '0; m_fsf = 1'b0; m_ftag = '0;
        end else begin
            req = (m_q.size() < DEPTH);
            sel = -1;
            if (!lsu_wait) begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (sel < 0) begin
                        ok = !m_q[i].wt;
                        for (int j = 0; j < i; j++)
                            if (m_conflict(m_q[i], m_q[j])) ok = 1'b0;
                        if (ok) sel = i;
                    end
                end
                if (sel >= 0) begin
                    m_fv = 1'b1; m_fpay = m_q[sel].payload; m_fk16 = m_q[sel].k16;
                    m_fd = m_q[sel].d; m_fsf = m_q[sel].sf; m_ftag = m_q[sel].tag;
                    m_q.delete(sel);
                end else begin
                    m_fv = 1'b0;
                end
            end
            if (lsu_data_wb)
                foreach (m_q[k])
                    if (m_q[k].wt && m_q[k].tag == lsu_data_tag) begin
                        m_q[k].k16 = lsu_data_in;
                        m_q[k].wt  = 1'b0;
                    end
            if (id_feed && req) begin
                u.payload = id_payload; u.k16 = id_k16; u.a = id_a_adr; u.b = id_b_adr;
                u.d = id_d_adr; u.sf = id_sf; u.ld = id_ld; u.st = id_st; u.wt = id_wait;
                u.tag = m_tag;
                m_q.push_back(u);
                m_tag = m_tag + 1'b1;
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("iss_valid", 32'(iss_valid), 32'(m_fv));
            check("count", 32'(count), 32'(m_q.size()));
            check("id_req", 32'(id_req), 32'(m_q.size() < DEPTH));
            check("iss_sf", 32'(iss_sf), 32'(m_fv & m_fsf & ~lsu_wait));
            if (m_fv) begin
                check("iss_payload", 32'(iss_payload), 32'(m_fpay));
                check("iss_k16", 32'(iss_k16), 32'(m_fk16));
                check("iss_d_adr", 32'(iss_d_adr), 32'(m_fd));
                check("iss_tag", 32'(iss_tag), 32'(m_ftag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [PW-1:0] p, input logic [15:0] k,
                        input logic [2:0] a, input logic [2:0] b, input logic [3:0] d,
                        input logic sf, input logic ld, input logic st, input logic wt);
        id_feed = 1'b1; id_payload = p; id_k16 = k; id_a_adr = a; id_b_adr = b;
        id_d_adr = d; id_sf = sf; id_ld = ld; id_st = st; id_wait = wt;
    endtask

    task automatic wb(input logic [TAG_W-1:0] t, input logic [15:0] data);
        lsu_data_wb = 1'b1; lsu_data_tag = t; lsu_data_in = data;
    endtask

    task automatic drain();
        int n;
        n = 0;
        id_feed = 1'b0; lsu_data_wb = 1'b0; lsu_wait = 1'b0;
        while ((m_q.size() != 0 || m_fv) && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(m_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [TAG_W-1:0] t0;
        a_rst = 1'b1; id_feed = 1'b0; id_payload = '0; id_k16 = '0; id_a_adr = '0;
        id_b_adr = '0; id_d_adr = '0; id_sf = 1'b0; id_ld = 1'b0; id_st = 1'b0;
        id_wait = 1'b0; lsu_data_wb = 1'b0; lsu_data_tag = '0; lsu_data_in = '0;
        lsu_wait = 1'b0;
        tick(); tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(iss_valid), 32'd0);
        check("rst_payload", 32'(iss_payload), 32'd0);
        check("rst_k16", 32'(iss_k16), 32'd0);
        check("rst_d", 32'(iss_d_adr), 32'd0);
        check("rst_sf", 32'(iss_sf), 32'd0);
        check("rst_tag", 32'(iss_tag), 32'd0);
        check("rst_req", 32'(id_req), 32'd1);
        a_rst = 1'b0;
        chk_en = 1'b1;

        // Reset in the middle of operation.
        feed(21'h00A01, 16'h0011, 3'd1, 3'd2, 4'd0, 0, 0, 0, 1); tick();
        feed(21'h00A02, 16'h0022, 3'd1, 3'd2, 4'd0, 0, 0, 0, 1); tick();
        feed(21'h00A03, 16'h0033, 3'd1, 3'd2, 4'd0, 0, 0, 0, 1); tick();
        id_feed = 1'b0;
        check("fill_count", 32'(count), 32'd3);
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_valid", 32'(iss_valid), 32'd0);
        check("rst2_req", 32'(id_req), 32'd1);
        feed(21'h00B01, 16'h5555, 3'd1, 3'd2, 4'd0, 0, 0, 0, 0); tick();
        id_feed = 1'b0; tick();
        check("rst2_iss_valid", 32'(iss_valid), 32'd1);
        check("rst2_iss_tag", 32'(iss_tag), 32'd0);
        check("rst2_iss_payload", 32'(iss_payload), 32'h00B01);
        drain();

        // RAW dependency behind a waiting producer.
        t0 = m_tag;
        feed(21'h0C001, 16'h0001, 3'd2, 3'd3, 4'b1001, 0, 0, 0, 1); tick();
        feed(21'h0C002, 16'h0002, 3'd1, 3'd4, 4'd0, 0, 0, 0, 0); tick();
        id_feed = 1'b0; tick(); tick(); tick();
        check("dep_blocked", 32'(iss_valid), 32'd0);
        check("dep_count", 32'(count), 32'd2);
        wb(t0, 16'h1234); tick(); lsu_data_wb = 1'b0;
        tick();
        check("dep_first", 32'(iss_payload), 32'h0C001);
        check("dep_first_k16", 32'(iss_k16), 32'h1234);
        tick();
        check("dep_second", 32'(iss_payload), 32'h0C002);
        check("dep_second_v", 32'(iss_valid), 32'd1);
        drain();

        // Bypass of a waiting uop; alloc, issue and wake-up in one cycle.
        t0 = m_tag;
        feed(21'h0D000, 16'h0000, 3'd5, 3'd6, 4'd0, 0, 0, 0, 1); tick();
        feed(21'h0D001, 16'h0101, 3'd1, 3'd2, 4'b1011, 0, 0, 0, 0); tick();
        feed(21'h0D002, 16'h0202, 3'd4, 3'd4, 4'd0, 0, 0, 0, 0);
        wb(t0, 16'hBEEF); tick();
        id_feed = 1'b0; lsu_data_wb = 1'b0;
        check("byp_first", 32'(iss_payload), 32'h0D001);
        check("byp_count", 32'(count), 32'd2);
        tick();
        check("byp_woken", 32'(iss_payload), 32'h0D000);
        check("byp_k16", 32'(iss_k16), 32'hBEEF);
        tick();
        check("byp_third", 32'(iss_payload), 32'h0D002);
        drain();

        // Full window with the LSU stalled, then issue+alloc at count 3.
        lsu_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            feed(21'h0E000 + PW'(i), 16'(i), 3'd0, 3'd0, 4'd0, 0, 0, 0, 0);
            tick();
            check("full_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
            if (i >= 3) check("full_req", 32'(id_req), 32'd0);
        end
        id_feed = 1'b0; lsu_wait = 1'b0; tick();
        check("full_rel_count", 32'(count), 32'd3);
        check("full_rel_pay", 32'(iss_payload), 32'h0E000);
        feed(21'h0E00A, 16'h00AA, 3'd0, 3'd0, 4'd0, 0, 0, 0, 0); tick();
        id_feed = 1'b0;
        check("full_same_count", 32'(count), 32'd3);
        check("full_same_pay", 32'(iss_payload), 32'h0E001);
        drain();

        // LSU stall holds the front and masks the flag write.
        feed(21'h0F001, 16'h7777, 3'd1, 3'd1, 4'b1010, 1, 0, 0, 0); tick();
        feed(21'h0F002, 16'h8888, 3'd3, 3'd3, 4'd0, 0, 0, 0, 0); tick();
        check("sf_live", 32'(iss_sf), 32'd1);
        id_feed = 1'b0; lsu_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pay", 32'(iss_payload), 32'h0F001);
            check("hold_valid", 32'(iss_valid), 32'd1);
            check("hold_sf", 32'(iss_sf), 32'd0);
            check("hold_count", 32'(count), 32'd1);
        end
        lsu_wait = 1'b0; tick();
        check("rel_pay", 32'(iss_payload), 32'h0F002);
        drain();

        // Store then load: the load stays behind the store.
        t0 = m_tag;
        feed(21'h10001, 16'h0000, 3'd1, 3'd2, 4'd0, 0, 0, 1, 1); tick();
        feed(21'h10002, 16'h0000, 3'd3, 3'd4, 4'd0, 0, 1, 0, 0); tick();
        id_feed = 1'b0; tick(); tick();
        check("mem_blocked", 32'(iss_valid), 32'd0);
        check("mem_count", 32'(count), 32'd2);
        wb(t0, 16'h00AA); tick(); lsu_data_wb = 1'b0;
        tick();
        check("mem_st_first", 32'(iss_payload), 32'h10001);
        tick();
        check("mem_ld_second", 32'(iss_payload), 32'h10002);
        drain();

        // Load then load: the younger one passes a waiting older one.
        t0 = m_tag;
        feed(21'h11001, 16'h0000, 3'd1, 3'd2, 4'd0, 0, 1, 0, 1); tick();
        feed(21'h11002, 16'h0000, 3'd3, 3'd4, 4'd0, 0, 1, 0, 0); tick();
        id_feed = 1'b0; tick();
        check("ldld_bypass", 32'(iss_payload), 32'h11002);
        check("ldld_bypass_v", 32'(iss_valid), 32'd1);
        wb(t0, 16'h0BB0); tick(); lsu_data_wb = 1'b0;
        tick();
        check("ldld_old", 32'(iss_payload), 32'h11001);
        check("ldld_old_k16", 32'(iss_k16), 32'h0BB0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
